// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle for gcd_engine.
// valid/ready: a transfer happens on a rising edge where both are high; valid holds its payload until then.
interface gcd_engine_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd;
    logic [CNT_W-1:0] cycles;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, gcd, cycles, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, gcd, cycles, busy
    );
endinterface

// File: rtl/gcd_engine.sv
// Sequential binary (Stein) GCD engine: one subtract/halve step per clock,
// result returned with a saturating count of compute cycles.
module gcd_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    gcd_engine_if.slave  bus,
    output logic [2:0]   dbg_state
);
    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, ALIGN, REDUCE, SCALE, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] ra, rb, res, gcd_r;
    logic [WIDTH-1:0] ra_nx, rb_nx, res_nx, gcd_nx;
    logic [K_W-1:0]   k, k_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cyc_r, cyc_nx, cnt_inc;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            k     <= '0;
            cnt   <= '0;
            gcd_r <= '0;
            cyc_r <= '0;
        end else begin
            state <= state_nx;
            ra    <= ra_nx;
            rb    <= rb_nx;
            res   <= res_nx;
            k     <= k_nx;
            cnt   <= cnt_nx;
            gcd_r <= gcd_nx;
            cyc_r <= cyc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ra_nx    = ra;
        rb_nx    = rb;
        res_nx   = res;
        k_nx     = k;
        cnt_nx   = cnt;
        gcd_nx   = gcd_r;
        cyc_nx   = cyc_r;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    ra_nx    = bus.a;
                    rb_nx    = bus.b;
                    k_nx     = '0;
                    cnt_nx   = '0;
                    state_nx = ALIGN;
                end
            end
            ALIGN: begin
                cnt_nx = cnt_inc;
                // A zero operand short-circuits straight to the result; no scaling needed.
                if (ra == '0 || rb == '0) begin
                    res_nx   = ra | rb;
                    k_nx     = '0;
                    gcd_nx   = ra | rb;
                    cyc_nx   = cnt_inc;
                    state_nx = DONE;
                end else if (!ra[0] && !rb[0]) begin
                    ra_nx = ra >> 1;
                    rb_nx = rb >> 1;
                    k_nx  = k + K_W'(1);
                end else begin
                    state_nx = REDUCE;
                end
            end
            REDUCE: begin
                cnt_nx = cnt_inc;
                if (ra == '0) begin
                    res_nx   = rb;
                    state_nx = SCALE;
                end else if (rb == '0) begin
                    res_nx   = ra;
                    state_nx = SCALE;
                end else if (!ra[0]) begin
                    ra_nx = ra >> 1;
                end else if (!rb[0]) begin
                    rb_nx = rb >> 1;
                end else if (ra >= rb) begin
                    ra_nx = ra - rb;
                end else begin
                    rb_nx = rb - ra;
                end
            end
            SCALE: begin
                cnt_nx   = cnt_inc;
                gcd_nx   = res << k;
                cyc_nx   = cnt_inc;
                state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.gcd       = gcd_r;
    assign bus.cycles    = cyc_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: three parameterisations sharing clock and reset,
// vector table, handshake corner sequences and random pairs against Euclid.
module tb_gcd_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd_engine_if #(.WIDTH(8),  .CNT_W(16)) bus8 ();
    gcd_engine_if #(.WIDTH(16), .CNT_W(4))  bus16 ();
    gcd_engine_if #(.WIDTH(4),  .CNT_W(16)) bus4 ();
    logic [2:0] dbg8, dbg16, dbg4;

    gcd_engine #(.WIDTH(8),  .CNT_W(16)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave),  .dbg_state(dbg8));
    gcd_engine #(.WIDTH(16), .CNT_W(4))  dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave), .dbg_state(dbg16));
    gcd_engine #(.WIDTH(4),  .CNT_W(16)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave),  .dbg_state(dbg4));

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        logic [15:0] cyc;
        bit          chk_lat;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // sel: 0 = WIDTH 8, 1 = WIDTH 16 / CNT_W 4, 2 = WIDTH 4
    task automatic set_in(input int sel, input logic v, input logic [15:0] av, input logic [15:0] bv);
        case (sel)
            0:       begin bus8.in_valid  = v; bus8.a  = av[7:0]; bus8.b  = bv[7:0]; end
            1:       begin bus16.in_valid = v; bus16.a = av;      bus16.b = bv;      end
            default: begin bus4.in_valid  = v; bus4.a  = av[3:0]; bus4.b  = bv[3:0]; end
        endcase
    endtask

    task automatic set_ordy(input int sel, input logic r);
        case (sel)
            0:       bus8.out_ready  = r;
            1:       bus16.out_ready = r;
            default: bus4.out_ready  = r;
        endcase
    endtask

    function automatic logic get_in_ready(input int sel);
        case (sel)
            0:       return bus8.in_ready;
            1:       return bus16.in_ready;
            default: return bus4.in_ready;
        endcase
    endfunction

    function automatic logic get_out_valid(input int sel);
        case (sel)
            0:       return bus8.out_valid;
            1:       return bus16.out_valid;
            default: return bus4.out_valid;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return bus8.busy;
            1:       return bus16.busy;
            default: return bus4.busy;
        endcase
    endfunction

    function automatic logic [15:0] get_gcd(input int sel);
        case (sel)
            0:       return 16'(bus8.gcd);
            1:       return bus16.gcd;
            default: return 16'(bus4.gcd);
        endcase
    endfunction

    function automatic logic [15:0] get_cycles(input int sel);
        case (sel)
            0:       return bus8.cycles;
            1:       return 16'(bus16.cycles);
            default: return bus4.cycles;
        endcase
    endfunction

    function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Submit one pair, return result once out_valid is seen; lat = edges after acceptance.
    task automatic run_job(input int sel, input logic [15:0] av, input logic [15:0] bv,
                           output logic [15:0] g, output logic [15:0] cyc, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!get_in_ready(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready never high (sel %0d)", sel);
        end
        set_in(sel, 1'b1, av, bv);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, '0, '0);
        check("busy_after_accept", 32'(get_busy(sel)), 1);
        check("in_ready_after_accept", 32'(get_in_ready(sel)), 0);
        lat = 0;
        while (!get_out_valid(sel) && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 3000) begin
            tests++; fails++;
            $display("FAIL result_timeout: out_valid never high (sel %0d a %0d b %0d)", sel, av, bv);
        end
        g   = get_gcd(sel);
        cyc = get_cycles(sel);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] g, cyc, ra, rb, mask;
        int lat;

        vecs[0] = '{0, 16'd48,    16'd18,  16'd6,   16'd10, 1'b1};
        vecs[1] = '{0, 16'd0,     16'd0,   16'd0,   16'd1,  1'b1};
        vecs[2] = '{0, 16'd0,     16'd200, 16'd200, 16'd1,  1'b1};
        vecs[3] = '{0, 16'd200,   16'd0,   16'd200, 16'd1,  1'b1};
        vecs[4] = '{0, 16'd255,   16'd255, 16'd255, 16'd4,  1'b1};
        vecs[5] = '{0, 16'd128,   16'd64,  16'd64,  16'd11, 1'b1};
        vecs[6] = '{0, 16'd35,    16'd14,  16'd7,   16'd8,  1'b1};
        vecs[7] = '{1, 16'd65535, 16'd1,   16'd1,   16'd15, 1'b0};
        vecs[8] = '{2, 16'd12,    16'd8,   16'd4,   16'd9,  1'b1};

        for (int s = 0; s < 3; s++) begin
            set_in(s, 1'b0, '0, '0);
            set_ordy(s, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus8.in_ready), 1);
        check("rst_out_valid", 32'(bus8.out_valid), 0);
        check("rst_busy", 32'(bus8.busy), 0);
        check("rst_gcd", 32'(bus8.gcd), 0);
        check("rst_cycles", 32'(bus8.cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_job(vecs[i].sel, vecs[i].a, vecs[i].b, g, cyc, lat);
            check($sformatf("vec%0d_gcd", i), 32'(g), 32'(vecs[i].g));
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            if (vecs[i].chk_lat) check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].cyc));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid_one_cycle", i), 32'(get_out_valid(vecs[i].sel)), 0);
        end

        // Backpressure: result held, a mid-DONE operand pulse must be dropped.
        set_ordy(0, 1'b0);
        run_job(0, 16'd48, 16'd18, g, cyc, lat);
        check("bp_gcd", 32'(g), 6);
        check("bp_cycles", 32'(cyc), 10);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) set_in(0, 1'b1, 16'd9, 16'd3);
            if (i == 2) set_in(0, 1'b0, '0, '0);
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(bus8.out_valid), 1);
            check("bp_hold_gcd", 32'(bus8.gcd), 6);
            check("bp_hold_cycles", 32'(bus8.cycles), 10);
            check("bp_hold_in_ready", 32'(bus8.in_ready), 0);
        end
        set_ordy(0, 1'b1);
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(bus8.out_valid), 0);
        check("bp_release_in_ready", 32'(bus8.in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_pulse_dropped", 32'(bus8.busy), 0);
            check("bp_gcd_kept_idle", 32'(bus8.gcd), 6);
        end
        run_job(0, 16'd9, 16'd3, g, cyc, lat);
        check("post_bp_gcd", 32'(g), 3);

        // Asynchronous reset while the engine is in REDUCE.
        @(negedge clk);
        set_in(0, 1'b1, 16'd48, 16'd18);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus8.busy), 0);
        check("midrst_out_valid", 32'(bus8.out_valid), 0);
        check("midrst_in_ready", 32'(bus8.in_ready), 1);
        check("midrst_gcd", 32'(bus8.gcd), 0);
        check("midrst_cycles", 32'(bus8.cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_stale", 32'(bus8.out_valid), 0);
        end
        run_job(0, 16'd35, 16'd14, g, cyc, lat);
        check("midrst_job_gcd", 32'(g), 7);
        check("midrst_job_cycles", 32'(cyc), 8);

        // Random pairs against Euclid for each width.
        for (int s = 0; s < 3; s++) begin
            mask = (s == 0) ? 16'h00ff : (s == 1) ? 16'hffff : 16'h000f;
            for (int i = 0; i < 20; i++) begin
                ra = 16'($urandom) & mask;
                rb = 16'($urandom) & mask;
                if ($urandom_range(0, 9) == 0) ra = '0;
                if ($urandom_range(0, 3) == 0) rb = ra & ~16'($urandom_range(0, 3));
                run_job(s, ra, rb, g, cyc, lat);
                check($sformatf("rand_w%0d_gcd(%0d,%0d)", s, ra, rb), 32'(g), 32'(ref_gcd(ra, rb)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
